// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
// Sticky overrun / framing-error flags are cleared by i_clr_err; a set in the same cycle wins.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_rx,
    input  logic       i_rd,
    input  logic       i_clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overrun,
    output logic       o_frame_err
);
    localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          push_req;
    logic          pop;
    logic          push;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_rx;
            rx_s  <= sync1;
        end
    end

    // Sampling lands mid-bit: START waits HALF cycles, every later bit waits DIV.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            if (i_clr_err) o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= CW'(HALF - 1);
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= CW'(DIV - 1);
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= CW'(DIV - 1);
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full     = (count == (PW + 1)'(FIFO_DEPTH));
    assign push_req = (state == STOP) && (cnt == '0) && rx_s;
    assign pop      = i_rd && (count != '0);
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && !push) o_overrun <= 1'b1;
            else if (i_clr_err)    o_overrun <= 1'b0;
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;
endmodule
